aq_gemac_udp_tx_packer: RTL and testbench
=========================================

// Module: aq_gemac_udp_tx_packer
// PURPOSE
//  Upstream feeder for the IP/UDP core's Send UDP port. Accepts a byte stream from user logic,
//  packs bytes big-endian into 32-bit words in a local FIFO and counts the length. On packet end
//  it issues SEND_REQUEST with the destination fields and streams the words on SEND_DATA_READ.
//  Holds one packet at a time; runs entirely in the SYS_CLK domain.
// PARAMETERS
//  FIFO_AW      8      FIFO address width; depth = 2**FIFO_AW words; max packet = 4*2**FIFO_AW bytes
//  TIMEOUT_CYC  1024   idle cycles before auto-close (only with AQ_GEMAC_TX_PACKER_TIMEOUT_EN)
// PORTS
//  SYS_CLK           in   1   system clock; all logic on rising edge
//  RST_N             in   1   reset, synchronous, active-low
//  IN_VALID          in   1   input byte valid
//  IN_READY          out  1   input byte accepted when IN_VALID & IN_READY
//  IN_DATA           in   8   payload byte
//  IN_LAST           in   1   qualifies final byte of packet
//  CFG_MAC_ADDRESS   in   48  destination MAC, sampled on first accepted byte
//  CFG_IP_ADDRESS    in   32  destination IP, sampled on first accepted byte
//  CFG_DST_PORT      in   16  UDP dst port, sampled on first accepted byte
//  CFG_SRC_PORT      in   16  UDP src port, sampled on first accepted byte
//  SEND_REQUEST      out  1   packet request to core
//  SEND_LENGTH       out  16  payload length in bytes
//  SEND_BUSY         in   1   core busy with request
//  SEND_MAC_ADDRESS  out  48  latched CFG_MAC_ADDRESS
//  SEND_IP_ADDRESS   out  32  latched CFG_IP_ADDRESS
//  SEND_DST_PORT     out  16  latched CFG_DST_PORT
//  SEND_SRC_PORT     out  16  latched CFG_SRC_PORT
//  SEND_DATA_VALID   out  1   FIFO head word valid
//  SEND_DATA_READ    in   1   core pops head word
//  SEND_DATA         out  32  FIFO head word (show-ahead)
//  PKT_SENT          out  1   1-cycle pulse: packet fully handed to core
//  PKT_DROP          out  1   1-cycle pulse: packet discarded (oversize)
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, byte counter 0; IN_READY=1 in IDLE; all other outputs 0.
//  - Packing: 1st byte of a word -> [31:24], 4th -> [7:0]; word written on 4th byte or on last.
//    Partial final word: unused low bytes are 0. SEND_LENGTH = exact byte count (1..4*depth).
//  - IDLE: IN_READY=1. First accepted byte latches CFG_* into SEND_* fields, count=1 ->
//    FILL, or -> REQ if IN_LAST also set.
//  - FILL: IN_READY=1; each accepted byte increments count. Accepting byte number 4*depth+1
//    -> DROP (FIFO flushed). Accepted IN_LAST -> REQ on next cycle, final word written.
//  - DROP: IN_READY=1, bytes discarded; on accepted IN_LAST: PKT_DROP pulse, count=0 -> IDLE.
//    Oversize byte carrying IN_LAST goes straight to IDLE with PKT_DROP.
//  - REQ: IN_READY=0; SEND_REQUEST=1 held until sampled SEND_BUSY=1, then deasserted -> XFER.
//  - XFER: IN_READY=0; SEND_DATA_VALID = FIFO non-empty; SEND_DATA_READ pops next cycle shows
//    next word. READ while empty is ignored (no underflow). FIFO empty & SEND_BUSY=0 ->
//    PKT_SENT pulse, count=0 -> IDLE (earliest new byte accepted cycle after PKT_SENT).
//  - SEND_* address/port/length outputs stable from REQ entry until return to IDLE.
//  - Reset mid-packet in any state: immediate return to reset values; partial packet lost.
//  - Latency: IN_LAST accepted at cycle n -> SEND_REQUEST=1 at n+1.
// CONFIGURATION
//  AQ_GEMAC_TX_PACKER_TIMEOUT_EN defined: in FILL, a counter clears on each accepted byte and
//   increments otherwise; reaching TIMEOUT_CYC closes the packet as if the last accepted byte
//   carried IN_LAST (-> REQ with current count). Not applied in IDLE/DROP/REQ/XFER.
//  Not defined: no counter; FILL waits indefinitely for IN_LAST.
// TESTING
//  1. 8 bytes 01..08, last on 08; core raises BUSY 2 cyc after REQ -> LENGTH=8,
//     words 01020304, 05060708, PKT_SENT once after BUSY falls.
//  2. 5 bytes AA..EE -> LENGTH=5, words AABBCCDD, EE000000; third READ ignored, VALID=0.
//  3. FIFO_AW=2, 17-byte packet -> no SEND_REQUEST, PKT_DROP once on last byte, then
//     2-byte packet 11,22 -> LENGTH=2, word 11220000.
//  4. Single byte 5A with IN_LAST in IDLE -> REQ next cycle, LENGTH=1, word 5A000000;
//     CFG_* changed after first byte do not affect SEND_* fields.
//  5. RST_N low during XFER with 2 words pending -> next cycle VALID=0, REQUEST=0, IN_READY=1.
//  6. TIMEOUT_EN, TIMEOUT_CYC=16: 3 bytes then idle 16 cycles -> REQ with LENGTH=3;
//     macro undefined: no REQ after 1000 idle cycles.

Source files
------------

// File: rtl/aq_gemac_udp_tx_packer.sv
// Byte-stream to 32-bit word packer feeding the UDP core's send port, one packet at a time.
// Optional idle auto-close in FILL is enabled by defining AQ_GEMAC_TX_PACKER_TIMEOUT_EN.
module aq_gemac_udp_tx_packer #(
  parameter int FIFO_AW     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        SYS_CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_LAST,
  input  logic [47:0] CFG_MAC_ADDRESS,
  input  logic [31:0] CFG_IP_ADDRESS,
  input  logic [15:0] CFG_DST_PORT,
  input  logic [15:0] CFG_SRC_PORT,
  output logic        SEND_REQUEST,
  output logic [15:0] SEND_LENGTH,
  input  logic        SEND_BUSY,
  output logic [47:0] SEND_MAC_ADDRESS,
  output logic [31:0] SEND_IP_ADDRESS,
  output logic [15:0] SEND_DST_PORT,
  output logic [15:0] SEND_SRC_PORT,
  output logic        SEND_DATA_VALID,
  input  logic        SEND_DATA_READ,
  output logic [31:0] SEND_DATA,
  output logic        PKT_SENT,
  output logic        PKT_DROP
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = FIFO_AW + 3;
  localparam logic [CNT_W-1:0]   MAX_BYTES = CNT_W'(4 * DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DROP, S_REQ, S_XFER} state_t;
  state_t state, state_next;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [31:0]        pack_buf, merged, wdata;
  logic [1:0]         byte_idx;
  logic [CNT_W-1:0]   byte_count;
  logic               fifo_empty;
  logic               take_byte, close_word, flush, pop, latch_cfg, write_en;

  assign fifo_empty = (wr_ptr == rd_ptr);
  // New byte lands in the lane selected by byte_idx, first byte in the top lane.
  assign merged     = pack_buf | ({IN_DATA, 24'h0} >> {byte_idx, 3'b000});
  assign wdata      = take_byte ? merged : pack_buf;
  assign write_en   = take_byte ? (byte_idx == 2'd3 || close_word)
                                : (close_word && byte_idx != 2'd0);
  assign SEND_LENGTH = 16'(byte_count);
  assign SEND_DATA   = SEND_DATA_VALID ? mem[rd_ptr[FIFO_AW-1:0]] : 32'h0;

`ifdef AQ_GEMAC_TX_PACKER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] idle_timer;
  logic             timeout_hit;

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N || state != S_FILL || IN_VALID) idle_timer <= '0;
    else                                       idle_timer <= idle_timer + TMR_W'(1);
  end

  assign timeout_hit = (state == S_FILL) && !IN_VALID && (idle_timer == TMR_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_next      = state;
    IN_READY        = 1'b0;
    SEND_REQUEST    = 1'b0;
    SEND_DATA_VALID = 1'b0;
    PKT_SENT        = 1'b0;
    PKT_DROP        = 1'b0;
    take_byte       = 1'b0;
    close_word      = 1'b0;
    flush           = 1'b0;
    pop             = 1'b0;
    latch_cfg       = 1'b0;
    case (state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          take_byte = 1'b1;
          latch_cfg = 1'b1;
          if (IN_LAST) begin
            close_word = 1'b1;
            state_next = S_REQ;
          end else begin
            state_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          if (byte_count == MAX_BYTES) begin
            flush = 1'b1;
            if (IN_LAST) begin
              PKT_DROP   = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_DROP;
            end
          end else begin
            take_byte = 1'b1;
            if (IN_LAST) begin
              close_word = 1'b1;
              state_next = S_REQ;
            end
          end
        end
`ifdef AQ_GEMAC_TX_PACKER_TIMEOUT_EN
        else if (timeout_hit) begin
          close_word = 1'b1;
          state_next = S_REQ;
        end
`endif
      end
      S_DROP: begin
        IN_READY = 1'b1;
        if (IN_VALID && IN_LAST) begin
          PKT_DROP   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_REQ: begin
        SEND_REQUEST = 1'b1;
        if (SEND_BUSY) state_next = S_XFER;
      end
      S_XFER: begin
        SEND_DATA_VALID = !fifo_empty;
        pop             = SEND_DATA_READ && !fifo_empty;
        if (fifo_empty && !SEND_BUSY) begin
          PKT_SENT   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pack_buf         <= '0;
      byte_idx         <= '0;
      byte_count       <= '0;
      SEND_MAC_ADDRESS <= '0;
      SEND_IP_ADDRESS  <= '0;
      SEND_DST_PORT    <= '0;
      SEND_SRC_PORT    <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        pack_buf <= '0;
        byte_idx <= '0;
      end else begin
        if (write_en) begin
          wr_ptr   <= wr_ptr + PTR_ONE;
          pack_buf <= '0;
          byte_idx <= '0;
        end else if (take_byte) begin
          pack_buf <= merged;
          byte_idx <= byte_idx + 2'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Length returns to zero whenever the packet finishes, is dropped, or nothing is pending.
      if (state_next == S_IDLE) byte_count <= '0;
      else if (latch_cfg)       byte_count <= CNT_ONE;
      else if (take_byte)       byte_count <= byte_count + CNT_ONE;
      if (latch_cfg) begin
        SEND_MAC_ADDRESS <= CFG_MAC_ADDRESS;
        SEND_IP_ADDRESS  <= CFG_IP_ADDRESS;
        SEND_DST_PORT    <= CFG_DST_PORT;
        SEND_SRC_PORT    <= CFG_SRC_PORT;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (write_en) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_aq_gemac_udp_tx_packer.sv
// Self-checking bench for aq_gemac_udp_tx_packer (4-word FIFO, 16-cycle timeout when enabled).
module tb_aq_gemac_udp_tx_packer;

  localparam int MAX_BYTES = 16;

  typedef logic [7:0]  bq_t [$];
  typedef logic [31:0] wq_t [$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic [47:0] cfg_mac;
  logic [31:0] cfg_ip;
  logic [15:0] cfg_dst, cfg_src;
  logic        send_request, send_busy, send_data_valid, send_data_read;
  logic [15:0] send_length;
  logic [47:0] send_mac;
  logic [31:0] send_ip;
  logic [15:0] send_dst, send_src;
  logic [31:0] send_data;
  logic        pkt_sent, pkt_drop;

  int tests = 0;
  int fails = 0;
  logic [47:0] exp_mac;
  logic [31:0] exp_ip;
  logic [15:0] exp_dst, exp_src;

  always #5 clk = ~clk;

  aq_gemac_udp_tx_packer #(.FIFO_AW(2), .TIMEOUT_CYC(16)) dut (
    .SYS_CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_LAST(in_last),
    .CFG_MAC_ADDRESS(cfg_mac), .CFG_IP_ADDRESS(cfg_ip),
    .CFG_DST_PORT(cfg_dst), .CFG_SRC_PORT(cfg_src),
    .SEND_REQUEST(send_request), .SEND_LENGTH(send_length), .SEND_BUSY(send_busy),
    .SEND_MAC_ADDRESS(send_mac), .SEND_IP_ADDRESS(send_ip),
    .SEND_DST_PORT(send_dst), .SEND_SRC_PORT(send_src),
    .SEND_DATA_VALID(send_data_valid), .SEND_DATA_READ(send_data_read), .SEND_DATA(send_data),
    .PKT_SENT(pkt_sent), .PKT_DROP(pkt_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomCfg();
    cfg_mac = {16'($urandom), 32'($urandom)};
    cfg_ip  = 32'($urandom);
    cfg_dst = 16'($urandom);
    cfg_src = 16'($urandom);
  endtask

  // Reference packing: byte i goes to word i/4, lane 3-(i%4); missing lanes stay zero.
  function automatic wq_t expectWords(input bq_t bytes);
    wq_t w;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i % 4 == 0) w.push_back(32'h0);
      w[i / 4] = w[i / 4] | (32'(bytes[i]) << (8 * (3 - (i % 4))));
    end
    return w;
  endfunction

  task automatic applyStimulus(input bq_t bytes, input bit with_last, input bit cfg_change);
    int n = bytes.size();
    bit oversize = (n > MAX_BYTES);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = bytes[i];
      in_last  = with_last && (i == n - 1);
      if (i == 0) begin
        exp_mac = cfg_mac; exp_ip = cfg_ip; exp_dst = cfg_dst; exp_src = cfg_src;
      end
      #1;
      checkOutput("in_ready_fill", 64'(in_ready), 64'd1);
      checkOutput("pkt_drop", 64'(pkt_drop), 64'(oversize && with_last && i == n - 1));
      checkOutput("no_req_fill", 64'(send_request), 64'd0);
      tick();
      if (cfg_change && i == 0) randomCfg();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic serveCore(input bq_t bytes, input int busy_delay, input bit extra_read);
    wq_t words = expectWords(bytes);
    int  idx = 0;
    #1;
    checkOutput("req_latency", 64'(send_request), 64'd1);
    checkOutput("in_ready_req", 64'(in_ready), 64'd0);
    checkOutput("length", 64'(send_length), 64'(bytes.size()));
    checkOutput("mac", 64'(send_mac), 64'(exp_mac));
    checkOutput("ip", 64'(send_ip), 64'(exp_ip));
    checkOutput("dst_port", 64'(send_dst), 64'(exp_dst));
    checkOutput("src_port", 64'(send_src), 64'(exp_src));
    for (int d = 0; d < busy_delay; d++) begin
      tick();
      checkOutput("req_held", 64'(send_request), 64'd1);
    end
    send_busy = 1'b1;
    tick();
    checkOutput("req_released", 64'(send_request), 64'd0);
    for (int c = 0; c < 100 && idx < words.size(); c++) begin
      send_data_read = 1'($urandom);
      #1;
      checkOutput("data_valid", 64'(send_data_valid), 64'd1);
      checkOutput("data_word", 64'(send_data), 64'(words[idx]));
      checkOutput("sent_early", 64'(pkt_sent), 64'd0);
      if (send_data_read) idx++;
      tick();
    end
    checkOutput("all_words_popped", 64'(idx), 64'(words.size()));
    if (extra_read) begin
      send_data_read = 1'b1;
      #1;
      checkOutput("valid_when_empty", 64'(send_data_valid), 64'd0);
      tick();
    end
    send_data_read = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      tick();
      checkOutput("sent_while_busy", 64'(pkt_sent), 64'd0);
    end
    checkOutput("length_stable", 64'(send_length), 64'(bytes.size()));
    send_busy = 1'b0;
    #1;
    checkOutput("pkt_sent", 64'(pkt_sent), 64'd1);
    tick();
    checkOutput("pkt_sent_pulse", 64'(pkt_sent), 64'd0);
    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
    checkOutput("length_cleared", 64'(send_length), 64'd0);
  endtask

  initial begin
    bq_t pkt;
    bit  saw_req;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0;
    send_busy = 1'b0; send_data_read = 1'b0;
    randomCfg();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_request", 64'(send_request), 64'd0);
    checkOutput("rst_valid", 64'(send_data_valid), 64'd0);
    checkOutput("rst_length", 64'(send_length), 64'd0);
    checkOutput("rst_data", 64'(send_data), 64'd0);
    checkOutput("rst_mac", 64'(send_mac), 64'd0);
    checkOutput("rst_sent_drop", 64'({pkt_sent, pkt_drop}), 64'd0);

    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(pkt, 1'b1, 1'b0);
    serveCore(pkt, 2, 1'b0);

    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    applyStimulus(pkt, 1'b1, 1'b0);
    serveCore(pkt, 1, 1'b1);

    pkt = {};
    for (int i = 0; i < 17; i++) pkt.push_back(8'($urandom));
    applyStimulus(pkt, 1'b1, 1'b0);
    #1;
    checkOutput("drop_no_req", 64'(send_request), 64'd0);
    checkOutput("drop_in_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("drop_pulse_end", 64'(pkt_drop), 64'd0);
    pkt = '{8'h11, 8'h22};
    applyStimulus(pkt, 1'b1, 1'b0);
    serveCore(pkt, 0, 1'b0);

    randomCfg();
    pkt = '{8'h5A};
    applyStimulus(pkt, 1'b1, 1'b1);
    serveCore(pkt, 3, 1'b1);

    for (int p = 0; p < 12; p++) begin
      randomCfg();
      pkt = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) pkt.push_back(8'($urandom));
      applyStimulus(pkt, 1'b1, 1'($urandom));
      if (pkt.size() > MAX_BYTES) begin
        #1;
        checkOutput("rand_drop_no_req", 64'(send_request), 64'd0);
      end else begin
        serveCore(pkt, int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(pkt, 1'b1, 1'b0);
    #1;
    checkOutput("pre_reset_req", 64'(send_request), 64'd1);
    send_busy = 1'b1;
    tick();
    checkOutput("pre_reset_valid", 64'(send_data_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("reset_xfer_valid", 64'(send_data_valid), 64'd0);
    checkOutput("reset_xfer_req", 64'(send_request), 64'd0);
    checkOutput("reset_xfer_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    send_busy = 1'b0;
    tick();

    pkt = '{8'hAA, 8'hBB, 8'hCC};
    applyStimulus(pkt, 1'b0, 1'b0);
    saw_req = 1'b0;
`ifdef AQ_GEMAC_TX_PACKER_TIMEOUT_EN
    for (int c = 0; c < 40 && !saw_req; c++) begin
      tick();
      saw_req = send_request;
    end
    checkOutput("timeout_req", 64'(saw_req), 64'd1);
    serveCore(pkt, 1, 1'b0);
`else
    repeat (1000) begin
      tick();
      saw_req = saw_req | send_request;
    end
    checkOutput("no_timeout_req", 64'(saw_req), 64'd0);
    applyStimulus('{8'hDD}, 1'b1, 1'b0);
    serveCore('{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
